// File: rtl/ipif_regbank_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ipif_regbank_pkg                                            |
// | Purpose  : Shared constants and helpers for the IPIF register bank:    |
// |            chip-enable one-hot check and byte-enable mask expansion.   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package ipif_regbank_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BYTES      = DATA_WIDTH / 8;

  // Upper bounds used to size the helper arguments; callers size-cast in/out.
  localparam int MAX_REG   = 64;
  localparam int MAX_CE    = 2 * MAX_REG;
  localparam int MAX_BYTES = 128;

  // True when exactly one chip-enable bit is set across both CE buses.
  function automatic logic onehot(input logic [MAX_CE-1:0] v);
    return $onehot(v);
  endfunction

  // Expand each byte-enable bit into eight data-bit mask bits.
  function automatic logic [MAX_BYTES*8-1:0] byte_mask(input logic [MAX_BYTES-1:0] be);
    logic [MAX_BYTES*8-1:0] m;
    for (int b = 0; b < MAX_BYTES; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipif_regbank_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ipif_regbank_if                                             |
// | Purpose  : IPIF bus bundle between the AXI-Lite IPIF (master) and the  |
// |            register bank (slave).                                      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface ipif_regbank_if
  import ipif_regbank_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = BYTES * 8,
  parameter int N_REG              = 4
);

  logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_bus2ip_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] IPIF_bus2ip_be;
  logic [N_REG-1:0]                IPIF_bus2ip_rdce;
  logic [N_REG-1:0]                IPIF_bus2ip_wrce;
  logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_ip2bus_data;
  logic                            IPIF_ip2bus_rdack;
  logic                            IPIF_ip2bus_wrack;
  logic                            IPIF_ip2bus_error;

  modport master (
    output IPIF_bus2ip_data, IPIF_bus2ip_be, IPIF_bus2ip_rdce, IPIF_bus2ip_wrce,
    input  IPIF_ip2bus_data, IPIF_ip2bus_rdack, IPIF_ip2bus_wrack, IPIF_ip2bus_error
  );

  modport slave (
    input  IPIF_bus2ip_data, IPIF_bus2ip_be, IPIF_bus2ip_rdce, IPIF_bus2ip_wrce,
    output IPIF_ip2bus_data, IPIF_ip2bus_rdack, IPIF_ip2bus_wrack, IPIF_ip2bus_error
  );

endinterface
`default_nettype wire

// File: rtl/ipif_access_tracker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ipif_access_tracker                                         |
// | Purpose  : Detects IPIF access starts, holds off re-triggering while a |
// |            CE stays asserted, classifies malformed CEs as errors and   |
// |            pipelines the single ack / read data per access.            |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ipif_access_tracker
  import ipif_regbank_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = BYTES * 8,
  parameter int N_REG              = 4,
  parameter int READ_LATENCY       = 1
) (
  input  logic                          clk,
  input  logic                          IPIF_bus2ip_resetn,
  input  logic [N_REG-1:0]              rdce,
  input  logic [N_REG-1:0]              wrce,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] rd_data,
  output logic                          wr_accept,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ip2bus_data,
  output logic                          rdack,
  output logic                          wrack,
  output logic                          error
);

  localparam int W    = C_S_AXI_DATA_WIDTH;
  localparam int LAST = READ_LATENCY - 1;

  logic         w_ce_any;
  logic         w_wr_any;
  logic         w_valid;
  logic         w_start;
  logic         w_rd_start;
  logic         r_armed;
  logic         r_wrack;
  logic         r_wr_err;
  logic         r_rd_vld [READ_LATENCY];
  logic         r_rd_err [READ_LATENCY];
  logic [W-1:0] r_rd_dat [READ_LATENCY];

  assign w_ce_any   = |{wrce, rdce};
  assign w_wr_any   = |wrce;
  assign w_valid    = onehot(MAX_CE'({wrce, rdce}));
  assign w_start    = w_ce_any & r_armed;
  assign w_rd_start = w_start & ~w_wr_any;
  assign wr_accept  = w_start & w_wr_any & w_valid;

  // Arm only after both CE buses are seen idle; resets disarmed so a CE held through reset never triggers.
  always_ff @(posedge clk or negedge IPIF_bus2ip_resetn) begin
    if (!IPIF_bus2ip_resetn) begin
      r_armed <= 1'b0;
    end else if (!w_ce_any) begin
      r_armed <= 1'b1;
    end else if (w_start) begin
      r_armed <= 1'b0;
    end
  end

  // Write ack (and write-side error) one cycle after the access start.
  always_ff @(posedge clk or negedge IPIF_bus2ip_resetn) begin
    if (!IPIF_bus2ip_resetn) begin
      r_wrack  <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_wrack  <= w_start & w_wr_any;
      r_wr_err <= w_start & w_wr_any & ~w_valid;
    end
  end

  // Read pipeline: data captured at access start, delayed READ_LATENCY cycles; zero when no ack.
  always_ff @(posedge clk or negedge IPIF_bus2ip_resetn) begin
    if (!IPIF_bus2ip_resetn) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_rd_vld[s] <= 1'b0;
        r_rd_err[s] <= 1'b0;
        r_rd_dat[s] <= '0;
      end
    end else begin
      r_rd_vld[0] <= w_rd_start;
      r_rd_err[0] <= w_rd_start & ~w_valid;
      r_rd_dat[0] <= (w_rd_start & w_valid) ? rd_data : '0;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_rd_vld[s] <= r_rd_vld[s-1];
        r_rd_err[s] <= r_rd_err[s-1];
        r_rd_dat[s] <= r_rd_dat[s-1];
      end
    end
  end

  assign wrack       = r_wrack;
  assign rdack       = r_rd_vld[LAST];
  assign ip2bus_data = r_rd_dat[LAST];
  assign error       = r_wr_err | r_rd_err[LAST];

endmodule
`default_nettype wire

// File: rtl/ipif_regbank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ipif_regbank                                                |
// | Purpose  : Parametrised IPIF register bank with byte-enable writes and |
// |            per-register RW / RO / pulse / sticky-W1C access modes.     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ipif_regbank
  import ipif_regbank_pkg::*;
#(
  parameter int                 C_S_AXI_DATA_WIDTH = BYTES * 8,
  parameter int                 N_REG              = 4,
  parameter type                PARAM_T            = logic [N_REG*C_S_AXI_DATA_WIDTH-1:0],
  parameter PARAM_T             DEFAULTS           = '0,
  parameter logic [N_REG-1:0]   RW_REG             = '1,
  parameter logic [N_REG-1:0]   PULSE_REG          = '0,
  parameter logic [N_REG-1:0]   W1C_REG            = '0,
  parameter int                 READ_LATENCY       = 1
) (
  input  logic             clk,
  input  logic             IPIF_bus2ip_resetn,
  ipif_regbank_if.slave    bus,
  output PARAM_T           parameters_out,
  input  PARAM_T           parameters_in,
  input  PARAM_T           status_set,
  output logic [N_REG-1:0] wr_strobe
);

  localparam int                     W       = C_S_AXI_DATA_WIDTH;
  localparam logic [N_REG*W-1:0]     DEF_VEC = DEFAULTS;

  logic [N_REG*W-1:0] w_regs;
  logic [N_REG*W-1:0] w_pin;
  logic [N_REG*W-1:0] w_status;
  logic [N_REG*W-1:0] w_rd_all;
  logic [W-1:0]       w_mask;
  logic [W-1:0]       w_wdat;
  logic [W-1:0]       w_rd_data;
  logic [W-1:0]       w_ip2bus_data;
  logic               w_wr_accept;
  logic               w_rdack;
  logic               w_wrack;
  logic               w_error;
  logic [N_REG-1:0]   w_wr_hit;
  logic [N_REG-1:0]   r_wr_strobe;

  assign w_pin    = parameters_in;
  assign w_status = status_set;
  assign w_mask   = W'(byte_mask(MAX_BYTES'(bus.IPIF_bus2ip_be)));
  assign w_wdat   = bus.IPIF_bus2ip_data & w_mask;
  assign w_wr_hit = bus.IPIF_bus2ip_wrce & {N_REG{w_wr_accept}};

  ipif_access_tracker #(
    .C_S_AXI_DATA_WIDTH (W),
    .N_REG              (N_REG),
    .READ_LATENCY       (READ_LATENCY)
  ) u_tracker (
    .clk                (clk),
    .IPIF_bus2ip_resetn (IPIF_bus2ip_resetn),
    .rdce               (bus.IPIF_bus2ip_rdce),
    .wrce               (bus.IPIF_bus2ip_wrce),
    .rd_data            (w_rd_data),
    .wr_accept          (w_wr_accept),
    .ip2bus_data        (w_ip2bus_data),
    .rdack              (w_rdack),
    .wrack              (w_wrack),
    .error              (w_error)
  );

  for (genvar i = 0; i < N_REG; i++) begin : g_reg
    logic [W-1:0] r_val;
    logic [W-1:0] w_next;
    logic [W-1:0] w_def;
    logic [W-1:0] w_set;

    assign w_def = DEF_VEC[i*W +: W];
    assign w_set = w_status[i*W +: W];

    // Next value by access mode; W1C overrides RW/PULSE, and a status set beats a same-cycle clear.
    always_comb begin
      w_next = r_val;
      if (W1C_REG[i]) begin
        w_next = (r_val & ~(w_wr_hit[i] ? w_wdat : '0)) | w_set;
      end else if (RW_REG[i] && PULSE_REG[i]) begin
        w_next = w_wr_hit[i] ? ((w_def & ~w_mask) | w_wdat) : w_def;
      end else if (RW_REG[i] && w_wr_hit[i]) begin
        w_next = (r_val & ~w_mask) | w_wdat;
      end
    end

    // Register storage, reset to the configured default.
    always_ff @(posedge clk or negedge IPIF_bus2ip_resetn) begin
      if (!IPIF_bus2ip_resetn) begin
        r_val <= DEF_VEC[i*W +: W];
      end else begin
        r_val <= w_next;
      end
    end

    assign w_regs[i*W +: W]   = r_val;
    assign w_rd_all[i*W +: W] = bus.IPIF_bus2ip_rdce[i] ?
                                (W1C_REG[i] ? r_val : w_pin[i*W +: W]) : '0;
  end

  // Read mux: with a valid one-hot rdce only one slice is non-zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < N_REG; i++) begin
      w_rd_data = w_rd_data | w_rd_all[i*W +: W];
    end
  end

  // Per-register write strobe, aligned with wrack.
  always_ff @(posedge clk or negedge IPIF_bus2ip_resetn) begin
    if (!IPIF_bus2ip_resetn) begin
      r_wr_strobe <= '0;
    end else begin
      r_wr_strobe <= w_wr_hit;
    end
  end

  assign parameters_out         = w_regs;
  assign wr_strobe              = r_wr_strobe;
  assign bus.IPIF_ip2bus_data   = w_ip2bus_data;
  assign bus.IPIF_ip2bus_rdack  = w_rdack;
  assign bus.IPIF_ip2bus_wrack  = w_wrack;
  assign bus.IPIF_ip2bus_error  = w_error;

endmodule
`default_nettype wire

// File: tb/tb_ipif_regbank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_ipif_regbank                                             |
// | Purpose  : Self-checking bench for ipif_regbank: table of single       |
// |            accesses plus hand-written multi-cycle sequences.           |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_ipif_regbank;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] DEF1   = {96'h0, 32'h0000_1234};
  localparam logic [127:0] DEF2   = {96'h0, 32'hCAFE_0000};
  localparam logic [95:0]  SET_LO = {96{1'b1}};
  localparam logic [31:0]  Z  = 32'h0;
  localparam logic [31:0]  D0 = 32'h0000_1234;
  localparam logic [31:0]  R0 = 32'hFF00_1234;
  localparam logic [31:0]  R1 = 32'h00AD_00EF;

  ipif_regbank_if #(.C_S_AXI_DATA_WIDTH(32), .N_REG(4)) bus1 ();
  ipif_regbank_if #(.C_S_AXI_DATA_WIDTH(32), .N_REG(4)) bus2 ();

  logic [127:0] po1, pin1, set1, po2, pin2, set2;
  logic [3:0]   strb1, strb2;

  ipif_regbank #(
    .C_S_AXI_DATA_WIDTH(32), .N_REG(4), .DEFAULTS(DEF1), .RW_REG(4'b0111),
    .PULSE_REG(4'b0100), .W1C_REG(4'b1000), .READ_LATENCY(1)
  ) dut1 (
    .clk(clk), .IPIF_bus2ip_resetn(rst_n), .bus(bus1), .parameters_out(po1),
    .parameters_in(pin1), .status_set(set1), .wr_strobe(strb1)
  );

  ipif_regbank #(
    .C_S_AXI_DATA_WIDTH(32), .N_REG(4), .DEFAULTS(DEF2), .RW_REG(4'b1110),
    .PULSE_REG(4'b0000), .W1C_REG(4'b0000), .READ_LATENCY(2)
  ) dut2 (
    .clk(clk), .IPIF_bus2ip_resetn(rst_n), .bus(bus2), .parameters_out(po2),
    .parameters_in(pin2), .status_set(set2), .wr_strobe(strb2)
  );

  typedef struct {
    logic [3:0]   wrce;
    logic [3:0]   rdce;
    logic [3:0]   be;
    logic [31:0]  data;
    logic [31:0]  set3;
    logic         e_wrack;
    logic         e_rdack;
    logic         e_err;
    logic [31:0]  e_data;
    logic [3:0]   e_strb;
    logic [127:0] e_po1;
    logic [127:0] e_po2;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] wrce, input logic [3:0] rdce, input logic [3:0] be,
                              input logic [31:0] data, input logic [31:0] set3,
                              input logic ewr, input logic erd, input logic eerr,
                              input logic [31:0] edat, input logic [3:0] estb,
                              input logic [127:0] epo1, input logic [127:0] epo2);
    vec_t v;
    v.wrce = wrce; v.rdce = rdce; v.be = be; v.data = data; v.set3 = set3;
    v.e_wrack = ewr; v.e_rdack = erd; v.e_err = eerr; v.e_data = edat;
    v.e_strb = estb; v.e_po1 = epo1; v.e_po2 = epo2;
    return v;
  endfunction

  task automatic idle1();
    bus1.IPIF_bus2ip_wrce = '0;
    bus1.IPIF_bus2ip_rdce = '0;
    bus1.IPIF_bus2ip_data = '0;
    bus1.IPIF_bus2ip_be   = '0;
    set1 = {Z, SET_LO};
  endtask

  task automatic idle2();
    bus2.IPIF_bus2ip_wrce = '0;
    bus2.IPIF_bus2ip_rdce = '0;
    bus2.IPIF_bus2ip_data = '0;
    bus2.IPIF_bus2ip_be   = '0;
  endtask

  // One access with CE in cycle n; checks cycle n+1 results and a quiet cycle n+2.
  task automatic run_vec(input int idx, input vec_t v);
    @(posedge clk); #1;
    bus1.IPIF_bus2ip_wrce = v.wrce;
    bus1.IPIF_bus2ip_rdce = v.rdce;
    bus1.IPIF_bus2ip_be   = v.be;
    bus1.IPIF_bus2ip_data = v.data;
    set1 = {v.set3, SET_LO};
    @(posedge clk); #1;
    idle1();
    @(negedge clk);
    chk($sformatf("v%0d.wrack", idx), 128'(bus1.IPIF_ip2bus_wrack), 128'(v.e_wrack));
    chk($sformatf("v%0d.rdack", idx), 128'(bus1.IPIF_ip2bus_rdack), 128'(v.e_rdack));
    chk($sformatf("v%0d.error", idx), 128'(bus1.IPIF_ip2bus_error), 128'(v.e_err));
    chk($sformatf("v%0d.rdata", idx), 128'(bus1.IPIF_ip2bus_data), 128'(v.e_data));
    chk($sformatf("v%0d.strobe", idx), 128'(strb1), 128'(v.e_strb));
    chk($sformatf("v%0d.params_n1", idx), po1, v.e_po1);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d.params_n2", idx), po1, v.e_po2);
    chk($sformatf("v%0d.quiet_n2", idx),
        128'({bus1.IPIF_ip2bus_wrack, bus1.IPIF_ip2bus_rdack, bus1.IPIF_ip2bus_error, strb1}), 128'(0));
    chk($sformatf("v%0d.data_n2", idx), 128'(bus1.IPIF_ip2bus_data), 128'(0));
  endtask

  initial begin
    int nw;
    int ns;
    int nr;

    pin1 = {32'hFFFF_FFFF, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    pin2 = {32'h4444_0003, 32'h5555_0002, 32'h6666_0001, 32'h1234_5678};
    set2 = '0;
    idle1();
    idle2();

    // Table: {wrce, rdce, be, data, set3, wrack, rdack, err, rdata, strobe, params n+1, params n+2}
    vecs.push_back(mk(4'b0010, 4'b0000, 4'b0101, 32'hDEADBEEF, Z,     1'b1, 1'b0, 1'b0, Z,            4'b0010, {Z, Z, R1, D0},            {Z, Z, R1, D0}));
    vecs.push_back(mk(4'b0001, 4'b0000, 4'b1000, 32'hFFFFFFFF, Z,     1'b1, 1'b0, 1'b0, Z,            4'b0001, {Z, Z, R1, R0},            {Z, Z, R1, R0}));
    vecs.push_back(mk(4'b0100, 4'b0000, 4'b1111, 32'h00000001, Z,     1'b1, 1'b0, 1'b0, Z,            4'b0100, {Z, 32'h1, R1, R0},        {Z, Z, R1, R0}));
    vecs.push_back(mk(4'b0000, 4'b0010, 4'b1111, 32'h0,        Z,     1'b0, 1'b1, 1'b0, 32'h22220001, 4'b0000, {Z, Z, R1, R0},            {Z, Z, R1, R0}));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0,        32'h5, 1'b0, 1'b0, 1'b0, Z,            4'b0000, {32'h5, Z, R1, R0},        {32'h5, Z, R1, R0}));
    vecs.push_back(mk(4'b0000, 4'b1000, 4'b0000, 32'h0,        Z,     1'b0, 1'b1, 1'b0, 32'h5,        4'b0000, {32'h5, Z, R1, R0},        {32'h5, Z, R1, R0}));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b1111, 32'h4,        Z,     1'b1, 1'b0, 1'b0, Z,            4'b1000, {32'h1, Z, R1, R0},        {32'h1, Z, R1, R0}));
    vecs.push_back(mk(4'b0000, 4'b1000, 4'b0000, 32'h0,        Z,     1'b0, 1'b1, 1'b0, 32'h1,        4'b0000, {32'h1, Z, R1, R0},        {32'h1, Z, R1, R0}));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b1111, 32'h1,        32'h1, 1'b1, 1'b0, 1'b0, Z,            4'b1000, {32'h1, Z, R1, R0},        {32'h1, Z, R1, R0}));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b1111, 32'hFFFFFFFF, Z,     1'b1, 1'b0, 1'b1, Z,            4'b0000, {32'h1, Z, R1, R0},        {32'h1, Z, R1, R0}));
    vecs.push_back(mk(4'b0000, 4'b1000, 4'b0000, 32'h0,        Z,     1'b0, 1'b1, 1'b0, 32'h1,        4'b0000, {32'h1, Z, R1, R0},        {32'h1, Z, R1, R0}));
    vecs.push_back(mk(4'b0000, 4'b0011, 4'b0000, 32'h0,        Z,     1'b0, 1'b1, 1'b1, Z,            4'b0000, {32'h1, Z, R1, R0},        {32'h1, Z, R1, R0}));
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b1111, 32'hFFFFFFFF, Z,     1'b1, 1'b0, 1'b1, Z,            4'b0000, {32'h1, Z, R1, R0},        {32'h1, Z, R1, R0}));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b1110, 32'h1,        Z,     1'b1, 1'b0, 1'b0, Z,            4'b1000, {32'h1, Z, R1, R0},        {32'h1, Z, R1, R0}));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b0001, 32'h1,        Z,     1'b1, 1'b0, 1'b0, Z,            4'b1000, {Z, Z, R1, R0},            {Z, Z, R1, R0}));
    vecs.push_back(mk(4'b0000, 4'b0001, 4'b0000, 32'h0,        Z,     1'b0, 1'b1, 1'b0, 32'h11110000, 4'b0000, {Z, Z, R1, R0},            {Z, Z, R1, R0}));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.params1", po1, DEF1);
    chk("rst.params2", po2, DEF2);
    chk("rst.acks1", 128'({bus1.IPIF_ip2bus_wrack, bus1.IPIF_ip2bus_rdack, bus1.IPIF_ip2bus_error, strb1}), 128'(0));
    chk("rst.data1", 128'(bus1.IPIF_ip2bus_data), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // Pulse register written with CE held for five cycles
    nw = 0;
    ns = 0;
    @(posedge clk); #1;
    bus1.IPIF_bus2ip_wrce = 4'b0100;
    bus1.IPIF_bus2ip_be   = 4'b0001;
    bus1.IPIF_bus2ip_data = 32'h0000_0003;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus1.IPIF_ip2bus_wrack) nw++;
      if (strb1[2]) ns++;
      if (k == 1) chk("pulse.n1", 128'(po1[95:64]), 128'(32'h3));
      if (k == 2) chk("pulse.n2", 128'(po1[95:64]), 128'(0));
      @(posedge clk); #1;
      if (k == 4) idle1();
    end
    chk("pulse.wrack_count", 128'(nw), 128'(1));
    chk("pulse.strobe_count", 128'(ns), 128'(1));

    // Back-to-back writes separated by one idle CE cycle
    @(posedge clk); #1;
    bus1.IPIF_bus2ip_wrce = 4'b0010;
    bus1.IPIF_bus2ip_be   = 4'b1111;
    bus1.IPIF_bus2ip_data = 32'h1111_1111;
    @(posedge clk); #1;
    idle1();
    @(negedge clk);
    chk("b2b.wrack_a", 128'(bus1.IPIF_ip2bus_wrack), 128'(1));
    chk("b2b.reg1_a", 128'(po1[63:32]), 128'(32'h1111_1111));
    @(posedge clk); #1;
    bus1.IPIF_bus2ip_wrce = 4'b0010;
    bus1.IPIF_bus2ip_be   = 4'b1111;
    bus1.IPIF_bus2ip_data = 32'h2222_2222;
    @(negedge clk);
    chk("b2b.gap", 128'(bus1.IPIF_ip2bus_wrack), 128'(0));
    @(posedge clk); #1;
    idle1();
    @(negedge clk);
    chk("b2b.wrack_b", 128'(bus1.IPIF_ip2bus_wrack), 128'(1));
    chk("b2b.reg1_b", 128'(po1[63:32]), 128'(32'h2222_2222));

    // Two-cycle read latency
    @(posedge clk); #1;
    bus2.IPIF_bus2ip_rdce = 4'b0001;
    @(posedge clk); #1;
    idle2();
    @(negedge clk);
    chk("rl2.n1_rdack", 128'(bus2.IPIF_ip2bus_rdack), 128'(0));
    chk("rl2.n1_data", 128'(bus2.IPIF_ip2bus_data), 128'(0));
    @(negedge clk);
    chk("rl2.n2_rdack", 128'(bus2.IPIF_ip2bus_rdack), 128'(1));
    chk("rl2.n2_data", 128'(bus2.IPIF_ip2bus_data), 128'(32'h1234_5678));
    chk("rl2.n2_error", 128'(bus2.IPIF_ip2bus_error), 128'(0));
    @(negedge clk);
    chk("rl2.n3_quiet", 128'({bus2.IPIF_ip2bus_rdack, bus2.IPIF_ip2bus_data}), 128'(0));

    // Write to a read-only register
    @(posedge clk); #1;
    bus2.IPIF_bus2ip_wrce = 4'b0001;
    bus2.IPIF_bus2ip_be   = 4'b1111;
    bus2.IPIF_bus2ip_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    idle2();
    @(negedge clk);
    chk("ro.wrack", 128'(bus2.IPIF_ip2bus_wrack), 128'(1));
    chk("ro.error", 128'(bus2.IPIF_ip2bus_error), 128'(0));
    chk("ro.strobe", 128'(strb2), 128'(4'b0001));
    chk("ro.params", po2, DEF2);

    // Reset while a read is pending, CE held across release
    @(posedge clk); #1;
    bus2.IPIF_bus2ip_rdce = 4'b0001;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.acks", 128'({bus2.IPIF_ip2bus_rdack, bus2.IPIF_ip2bus_wrack, bus2.IPIF_ip2bus_error, strb2}), 128'(0));
    chk("rstmid.data", 128'(bus2.IPIF_ip2bus_data), 128'(0));
    chk("rstmid.params1", po1, DEF1);
    chk("rstmid.params2", po2, DEF2);
    @(negedge clk);
    chk("rstmid.no_rdack", 128'(bus2.IPIF_ip2bus_rdack), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    nr = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus2.IPIF_ip2bus_rdack) nr++;
    end
    chk("rstmid.held_ce_acks", 128'(nr), 128'(0));
    @(posedge clk); #1;
    idle2();
    @(posedge clk); #1;
    bus2.IPIF_bus2ip_rdce = 4'b0001;
    @(posedge clk); #1;
    idle2();
    @(negedge clk);
    chk("rstmid.re_n1", 128'(bus2.IPIF_ip2bus_rdack), 128'(0));
    @(negedge clk);
    chk("rstmid.re_rdack", 128'(bus2.IPIF_ip2bus_rdack), 128'(1));
    chk("rstmid.re_data", 128'(bus2.IPIF_ip2bus_data), 128'(32'h1234_5678));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
